// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter family: direction encodings and
// the terminal-value helper.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Terminal value is M-1 modulo 2^w, so M=0 selects the full 2^w range.
    function automatic logic [31:0] term_of(input logic [31:0] m, input int w);
        logic [31:0] mask;
        if (w >= 32) begin
            mask = '1;
        end else begin
            mask = (32'd1 << w) - 32'd1;
        end
        return (m - 32'd1) & mask;
    endfunction

endpackage

// File: rtl/mod_counter_step.sv
// Combinational next-count and terminal-flag logic for one modulo counter
// channel; shared with multi-channel scan logic.
module mod_counter_step
    import counter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] term_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] next_o,
    output logic             term_hit_o
);

    always_comb begin
        next_o     = count_i;
        term_hit_o = 1'b0;
        if (up_i == DIR_UP) begin
            // >= lets an out-of-range count left by a modulus shrink wrap to 0.
            term_hit_o = (count_i >= term_i);
            next_o     = term_hit_o ? '0 : count_i + 1'b1;
        end else begin
            term_hit_o = (count_i == '0);
            next_o     = (term_hit_o || (count_i > term_i)) ? term_i : count_i - 1'b1;
        end
    end

endmodule

// File: rtl/mod_counter_ud.sv
// Up/down modulo-M counter with runtime modulus, clamped load, tc and wrap.
// Define MOD_COUNTER_ONESHOT_EN to halt at the terminal value and raise done.
module mod_counter_ud
    import counter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MOD   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] modulus,
    output logic             tc,
    output logic             wrap,
    output logic             done
);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] mod_q, mod_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] step_next;
    logic             step_tc;

    assign term = WIDTH'(term_of(32'(mod_q), WIDTH));

    mod_counter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .count_i   (count_q),
        .term_i    (term),
        .up_i      (up),
        .next_o    (step_next),
        .term_hit_o(step_tc)
    );

`ifdef MOD_COUNTER_ONESHOT_EN
    logic done_q, done_d;

    always_comb begin
        done_d = done_q;
        if (load) begin
            done_d = 1'b0;
        end else if (en && !done_q && step_tc) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
        end
    end

    assign done = done_q;
`else
    assign done = 1'b0;
`endif

    assign tc = en && !load && !done && step_tc;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (load_val > term) ? term : load_val;
        end else if (en && !done) begin
`ifdef MOD_COUNTER_ONESHOT_EN
            // A terminal step parks on the terminal value instead of wrapping.
            if (step_tc) begin
                count_d = (up == DIR_UP) ? term : '0;
            end else begin
                count_d = step_next;
            end
`else
            count_d = step_next;
`endif
        end
    end

    always_comb begin
        mod_d  = mod_wr ? mod_val : mod_q;
        wrap_d = tc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
            mod_q   <= WIDTH'(MOD);
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            mod_q   <= mod_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count   = count_q;
    assign modulus = mod_q;
    assign wrap    = wrap_q;

endmodule
